// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation over valid/ready, holds ALU inputs for a per-op settle time, returns ZHigh/ZLow
//   Optional feature macro: ALU_SEQ_DIVZ_EN (divide-by-zero is reported as an error without running the ALU).
//   Ports:
//     clock_i, clear_i           clock, synchronous active-high reset
//     req_valid_i/req_ready_o    request handshake; req_op_i, req_a_i, req_b_i carry the operation
//     alu_a_o, alu_b_o, alu_sel_o  operands and select driven to the ALU (select is 0 outside EXEC)
//     alu_zhigh_i, alu_zlow_i    ALU results, captured on the last settle cycle
//     rsp_valid_o/rsp_ready_i    response handshake; rsp_hi_o, rsp_lo_o, rsp_err_o carry the result
//     busy_o                     sequencer not idle
module alu_op_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int SEL_WIDTH    = 16,
  parameter int BASIC_CYCLES = 1,
  parameter int MUL_CYCLES   = 4,
  parameter int DIV_CYCLES   = 8
) (
  input  logic                  clock_i,
  input  logic                  clear_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [SEL_WIDTH-1:0]  alu_sel_o,
  input  logic [DATA_WIDTH-1:0] alu_zhigh_i,
  input  logic [DATA_WIDTH-1:0] alu_zlow_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_hi_o,
  output logic [DATA_WIDTH-1:0] rsp_lo_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam int MAX_S = (BASIC_CYCLES > MUL_CYCLES ? BASIC_CYCLES : MUL_CYCLES) > DIV_CYCLES ?
                         (BASIC_CYCLES > MUL_CYCLES ? BASIC_CYCLES : MUL_CYCLES) : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_S + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_init;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [3:0] sel_q, sel_d;
  logic err_q, err_d, skip;
  assign cnt_init = req_op_i == 4'd14 ? CNT_W'(MUL_CYCLES - 1) :
                    req_op_i == 4'd15 ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(BASIC_CYCLES - 1);
  // Operations that never reach the ALU go straight to DONE with an error response.
`ifdef ALU_SEQ_DIVZ_EN
  assign skip = req_op_i == 4'd0 || (req_op_i == 4'd15 && req_b_i == '0);
`else
  assign skip = req_op_i == 4'd0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    sel_d = sel_q;
    hi_d = hi_q;
    lo_d = lo_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        a_d = req_a_i;
        b_d = req_b_i;
        if (skip) begin
          hi_d = '0;
          lo_d = '0;
          err_d = 1'b1;
          state_d = DONE;
        end else begin
          sel_d = req_op_i;
          cnt_d = cnt_init;
          state_d = EXEC;
        end
      end
      EXEC: if (cnt_q == '0) begin
        hi_d = alu_zhigh_i;
        lo_d = alu_zlow_i;
        err_d = 1'b0;
        sel_d = '0;
        state_d = DONE;
      end else cnt_d = cnt_q - CNT_W'(1);
      DONE: if (rsp_ready_i) begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      err_q <= err_d;
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign rsp_valid_o = state_q == DONE;
  assign alu_a_o = a_q;
  assign alu_b_o = b_q;
  assign alu_sel_o = SEL_WIDTH'(sel_q);
  assign rsp_hi_o = hi_q;
  assign rsp_lo_o = lo_q;
  assign rsp_err_o = err_q;
endmodule
